// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller for the RV32I lw/sw/beq/add/sub/and/or subset.
// Moore decode of a one-hot-free 4-bit state plus cycle and retired-instruction counters.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             branch,
    output logic             pcsrc,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [3:0]       aluctrl,
    output logic [3:0]       state,
    output logic             retire,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_LDWB   = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_R   = 7'b0110011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cycle_q, instret_q;
    logic [6:0]       opcode;
    logic [3:0]       r_alu;
    logic             unused_instr;

    assign opcode       = instr[6:0];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    // Unrecognised funct combinations fall back to add.
    always_comb begin
        r_alu = ALU_ADD;
        case ({instr[30], instr[14:12]})
            4'b1000: r_alu = ALU_SUB;
            4'b0111: r_alu = ALU_AND;
            4'b0110: r_alu = ALU_OR;
            default: r_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d  = S_FETCH;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        pcsrc    = 1'b0;
        iord     = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluctrl  = ALU_ADD;
        retire   = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b10;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
                state_d = mem_ready ? S_LDWB : S_MEMRD;
            end
            S_LDWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                retire   = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                retire   = mem_ready;
                state_d  = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluctrl = r_alu;
                state_d = S_RWB;
            end
            S_RWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            S_BEQ: begin
                alusrca = 1'b1;
                aluctrl = ALU_SUB;
                branch  = 1'b1;
                pcsrc   = 1'b1;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset suppresses every side-effecting strobe, even mid-wait.
        if (rst) begin
            pcwrite  = 1'b0;
            branch   = 1'b0;
            memread  = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            retire   = 1'b0;
            illegal  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_q + CNT_W'(1);
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign state       = state_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: planned per-instruction stimulus, expected state
// trace and retire records queued by a reference model, checked by a negedge monitor.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_ready = 1'b0;
    logic [31:0] instr = 32'h0;

    logic        pcwrite, branch, pcsrc, iord, memread, memwrite, irwrite;
    logic        memtoreg, regwrite, alusrca, retire, illegal;
    logic [1:0]  alusrcb;
    logic [3:0]  aluctrl, state;
    logic [31:0] cycle_cnt, instret_cnt;

    logic        pcwrite4, branch4, pcsrc4, iord4, memread4, memwrite4, irwrite4;
    logic        memtoreg4, regwrite4, alusrca4, retire4, illegal4;
    logic [1:0]  alusrcb4;
    logic [3:0]  aluctrl4, state4;
    logic [3:0]  cycle_cnt4, instret_cnt4;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .branch(branch), .pcsrc(pcsrc), .iord(iord),
        .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluctrl(aluctrl), .state(state), .retire(retire),
        .illegal(illegal), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    multicycle_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .pcwrite(pcwrite4), .branch(branch4), .pcsrc(pcsrc4), .iord(iord4),
        .memread(memread4), .memwrite(memwrite4), .irwrite(irwrite4),
        .memtoreg(memtoreg4), .regwrite(regwrite4), .alusrca(alusrca4),
        .alusrcb(alusrcb4), .aluctrl(aluctrl4), .state(state4), .retire(retire4),
        .illegal(illegal4), .cycle_cnt(cycle_cnt4), .instret_cnt(instret_cnt4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         lat;
        bit         ill;
        logic [3:0] alu;
    } exp_t;

    exp_t sb[$];
    int   sq[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;
    int   cyc_model = 0;
    int   ret_model = 0;
    int   cyc_in = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] r_alu(input logic [31:0] i);
        case ({i[30], i[14:12]})
            4'b1000: return 4'b0110;
            4'b0111: return 4'b0000;
            4'b0110: return 4'b0001;
            default: return 4'b0010;
        endcase
    endfunction

    // {pcwrite,branch,iord,memread,memwrite,irwrite,regwrite,retire,illegal}
    function automatic logic [8:0] exp_strb(input int es, input logic rdy, input bit ill);
        case (es)
            0:       return {rdy, 1'b0, 1'b0, 1'b1, 1'b0, rdy, 1'b0, 1'b0, 1'b0};
            1:       return {8'b0, ill};
            3:       return 9'b001100000;
            4:       return 9'b000000110;
            5:       return {7'b0010100, rdy, 1'b0};
            7:       return 9'b000000110;
            8:       return 9'b010000010;
            default: return 9'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        int         es;
        exp_t       e;
        bit         ill_f;
        logic [3:0] alu_f;
        if (rst) begin
            chk("rst_strobes", 64'({pcwrite, branch, memread, memwrite, irwrite, regwrite, retire, illegal}), 64'(0));
            chk("rst_strobes4", 64'({pcwrite4, branch4, memread4, memwrite4, irwrite4, regwrite4, retire4, illegal4}), 64'(0));
            cyc_model = 0;
            ret_model = 0;
            cyc_in    = 0;
        end else if (!done) begin
            ill_f = (sb.size() > 0) ? sb[0].ill : 1'b0;
            alu_f = (sb.size() > 0) ? sb[0].alu : 4'b0010;
            if (sq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL state_underflow: got state %0d expected none queued at %0t", state, $time);
            end else begin
                es = sq.pop_front();
                chk("state", 64'(state), 64'(es));
                chk("strobes", 64'({pcwrite, branch, iord, memread, memwrite, irwrite, regwrite, retire, illegal}),
                    64'(exp_strb(es, mem_ready, ill_f)));
                if (es == 6) begin
                    chk("exec_alu", 64'(aluctrl), 64'(alu_f));
                    chk("exec_src", 64'({alusrca, alusrcb}), 64'(3'b100));
                end
                if (es == 8) chk("beq_ctl", 64'({aluctrl, pcsrc}), 64'(5'b01101));
                if (es == 4) chk("ldwb_m2r", 64'(memtoreg), 64'(1));
                if (es == 7) chk("rwb_ctl", 64'({memtoreg, aluctrl}), 64'(5'b00010));
            end
            chk("cycle_cnt", 64'(cycle_cnt), 64'(cyc_model));
            chk("cycle_cnt4", 64'(cycle_cnt4), 64'(cyc_model % 16));
            cyc_in++;
            if (retire || illegal) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got retire=%0b illegal=%0b expected no completion", retire, illegal);
                end else begin
                    e = sb.pop_front();
                    chk("latency", 64'(cyc_in), 64'(e.lat));
                    chk("kind_illegal", 64'(illegal), 64'(e.ill));
                end
                if (retire) begin
                    chk("instret_cnt", 64'(instret_cnt), 64'(ret_model));
                    chk("instret_cnt4", 64'(instret_cnt4), 64'(ret_model % 16));
                    ret_model++;
                end
                cyc_in = 0;
            end
            cyc_model++;
        end
    end

    // Plans one instruction: fw fetch waits, mw memory waits (lw/sw only).
    task automatic issue(input logic [31:0] ins, input int fw, input int mw);
        int   cls;
        int   ms;
        exp_t e;
        logic r;
        case (ins[6:0])
            7'b0000011: cls = 0;
            7'b0100011: cls = 1;
            7'b0110011: cls = 2;
            7'b1100011: cls = 3;
            default:    cls = 4;
        endcase
        e.ill = (cls == 4);
        e.alu = (cls == 2) ? r_alu(ins) : 4'b0010;
        e.lat = 0;
        repeat (fw + 1) begin sq.push_back(0); e.lat++; end
        sq.push_back(1); e.lat++;
        case (cls)
            0: begin
                sq.push_back(2); e.lat++;
                repeat (mw + 1) begin sq.push_back(3); e.lat++; end
                sq.push_back(4); e.lat++;
            end
            1: begin
                sq.push_back(2); e.lat++;
                repeat (mw + 1) begin sq.push_back(5); e.lat++; end
            end
            2: begin sq.push_back(6); sq.push_back(7); e.lat += 2; end
            3: begin sq.push_back(8); e.lat++; end
            default: ;
        endcase
        sb.push_back(e);
        instr = ins;
        ms = fw + 3;
        for (int k = 0; k < e.lat; k++) begin
            if (k < fw) r = 1'b0;
            else if (k == fw) r = 1'b1;
            else if (cls <= 1 && k >= ms && k < ms + mw) r = 1'b0;
            else if (cls <= 1 && k == ms + mw) r = 1'b1;
            else r = 1'($urandom_range(0, 1));
            mem_ready = r;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic abort_lw();
        exp_t e;
        e.lat = 6;
        e.ill = 1'b0;
        e.alu = 4'b0010;
        sb.push_back(e);
        sq.push_back(0); sq.push_back(1); sq.push_back(2); sq.push_back(3); sq.push_back(3);
        instr = 32'h0080af03;
        mem_ready = 1'b1; @(posedge clk); #1;
        mem_ready = 1'b0; @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        mem_ready = 1'b1;
        sb.delete();
        sq.delete();
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] ins;
        logic [3:0]  sel;
        logic [3:0]  sels [4];
        int          cls;
        sels[0] = 4'b0000; sels[1] = 4'b1000; sels[2] = 4'b0111; sels[3] = 4'b0110;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        issue(32'h00208f33, 0, 0);
        issue(32'h40208f33, 0, 0);
        issue(32'h0020ef33, 0, 0);
        issue(32'h0020ff33, 0, 0);
        issue(32'h0080af03, 0, 2);
        issue(32'hfe20aa23, 0, 0);
        issue(32'hfeb289e3, 0, 0);
        issue(32'h00000013, 0, 0);
        issue(32'h00208f33, 2, 0);
        issue(32'hfe20aa23, 1, 2);
        for (int n = 0; n < 60; n++) begin
            ins = $urandom;
            cls = $urandom_range(0, 4);
            case (cls)
                0: ins[6:0] = 7'b0000011;
                1: ins[6:0] = 7'b0100011;
                2: begin
                    ins[6:0] = 7'b0110011;
                    sel = ($urandom_range(0, 4) == 0) ? 4'($urandom) : sels[$urandom_range(0, 3)];
                    ins[30] = sel[3];
                    ins[14:12] = sel[2:0];
                end
                3: ins[6:0] = 7'b1100011;
                default: begin
                    while (ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0100011 ||
                           ins[6:0] == 7'b0110011 || ins[6:0] == 7'b1100011)
                        ins[6:0] = 7'($urandom);
                end
            endcase
            issue(ins, $urandom_range(0, 2), $urandom_range(0, 2));
        end
        abort_lw();
        issue(32'h00208f33, 0, 0);
        issue(32'h0080af03, 1, 0);
        done = 1'b1;
        chk("sb_drained", 64'(sb.size()), 64'(0));
        chk("sq_drained", 64'(sq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle main controller FSM for the RV32I subset lw/sw/beq/add/sub/and/or.
- Sequences the shared PC/IR/ALU/memory/regfile datapath over several cycles per instruction. Uses the same ALU control encoding as the single-cycle control unit.
- Stalls on a memory ready handshake.
- Keeps retired-instruction and cycle performance counters.

Parameters:
- CNT_W, 32, width of cycle_cnt and instret_cnt (wrap modulo 2^CNT_W).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  32  current IR contents (stable from DECODE until the instruction retires)
- mem_ready  in  1  memory completes the current read/write this cycle
- pcwrite  out  1  unconditional PC load
- branch  out  1  conditional PC load if ALU zero
- pcsrc  out  1  0: PC<=ALU result, 1: PC<=ALUOut (branch target)
- iord  out  1  0: memory address=PC, 1: address=ALUOut
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- irwrite  out  1  IR load
- memtoreg  out  1  1: regfile write data from MDR, 0: from ALUOut
- regwrite  out  1  regfile write enable
- alusrca  out  1  0: A=PC, 1: A=rs1 register
- alusrcb  out  2  00: rs2 register, 01: constant 4, 10: immediate
- aluctrl  out  4  0000 and, 0001 or, 0010 add, 0110 sub
- state  out  4  current state code (debug)
- retire  out  1  one-cycle pulse on the last cycle of a legal instruction
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode
- cycle_cnt  out  CNT_W  cycles since reset
- instret_cnt  out  CNT_W  retired instructions since reset

Behaviour:
- Reset (rst=1 at clk edge): state<=FETCH (code 0), cycle_cnt<=0, instret_cnt<=0.
- While rst=1, all strobe outputs are forced 0: pcwrite, branch, memread, memwrite, irwrite, regwrite, retire, illegal.
- Outputs are Moore decodes of state. mem_ready gating applies only where listed below. Every output not listed for a state is 0; aluctrl defaults to 0010.
- Opcodes, from instr[6:0]: lw 0000011, sw 0100011, beq 1100011, R-type 0110011.
- R-type ALU select {instr[30],instr[14:12]}: 0000 add, 1000 sub, 0111 and, 0110 or. Any other value maps to add.
- FETCH (0): iord=0, memread=1, alusrca=0, alusrcb=01, aluctrl=0010. irwrite=pcwrite=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE (1): alusrca=0, alusrcb=10, add (branch target into ALUOut). Next state by opcode:
  - lw or sw -> MEMADR
  - R-type -> EXEC
  - beq -> BEQ
  - other -> FETCH with illegal=1; no retire.
- MEMADR (2): alusrca=1, alusrcb=10, add. Next: MEMRD if lw, MEMWR if sw.
- MEMRD (3): iord=1, memread=1. Hold until mem_ready=1, then go to LDWB.
- LDWB (4): regwrite=1, memtoreg=1, retire=1. Next: FETCH.
- MEMWR (5): iord=1, memwrite=1. retire=mem_ready. Hold until mem_ready=1, then go to FETCH.
- EXEC (6): alusrca=1, alusrcb=00, aluctrl from the R-type select. Next: RWB.
- RWB (7): regwrite=1, memtoreg=0, retire=1. Next: FETCH.
- BEQ (8): alusrca=1, alusrcb=00, aluctrl=0110, branch=1, pcsrc=1, retire=1. Next: FETCH.
- Unused codes 9-15 -> FETCH next cycle, all strobes 0.
- Latency with mem_ready always 1, FETCH to retire inclusive: lw 5, sw 4, R-type 4, beq 3 cycles. Each wait cycle with mem_ready=0 adds 1 cycle.
- Counters:
  - cycle_cnt increments every non-reset cycle.
  - instret_cnt increments on each cycle with retire=1.
  - Both wrap to 0 after all-ones. No saturation.
- Reset mid-instruction (any state, including memory waits) aborts the instruction. No retire, no counter update that cycle. FETCH next cycle.
- mem_ready is ignored in states with no memory access.

Test Plan:
- Reset, then hold mem_ready=1 and give instr=0x00208f33 (add) -> states 0,1,6,7,0. RWB has regwrite=1, memtoreg=0, aluctrl=0010. instret_cnt=1 and cycle_cnt=4 after RWB.
- instr=0x40208f33 (sub), 0x0020ef33 (or), 0x0020ff33 (and) -> EXEC aluctrl=0110, 0001, 0000 respectively, each with alusrca=1, alusrcb=00.
- instr=0x0080af03 (lw), mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. memread=1, iord=1 throughout MEMRD. LDWB has regwrite=1, memtoreg=1. Latency 7 cycles.
- instr=0xfe20aa23 (sw) -> MEMWR memwrite=1, iord=1. regwrite is never 1. beq 0xfeb289e3 -> BEQ branch=1, pcsrc=1, aluctrl=0110. Latency 3 cycles.
- instr=0x00000013 (addi, unsupported) -> illegal=1 in DECODE, back to FETCH. instret_cnt is unchanged.
- Assert rst during MEMRD wait -> next state 0, all strobes 0 while rst=1, both counters 0.
- CNT_W=4: retire 16 instructions -> instret_cnt wraps to 0.
